// File: rtl/regfile_ctrl_pkg.sv
// Shared types and defaults for the register-file writeback control slice.
package regfile_ctrl_pkg;

    localparam int unsigned REG_IDX_W        = 5;
    localparam int unsigned DEFAULT_NUM_REG  = 32;
    localparam int unsigned DEFAULT_DATA_W   = 32;
    localparam int unsigned DEFAULT_MAX_WAIT = 3;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } arb_state_e;

    // x0 is hardwired to zero: never written, never tracked as busy.
    function automatic logic is_x0(input reg_idx_t r);
        return (r == '0);
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request handshakes (ALU = A, load/CSR = B) and the register file write port.
interface regfile_wb_arbiter_if #(
    parameter int unsigned DATA_W = 32
);
    import regfile_ctrl_pkg::*;

    logic              a_valid;
    logic              a_ready;
    reg_idx_t          a_reg;
    logic [DATA_W-1:0] a_data;

    logic              b_valid;
    logic              b_ready;
    reg_idx_t          b_reg;
    logic [DATA_W-1:0] b_data;

    logic              rf_write_en;
    reg_idx_t          rf_write_reg;
    logic [DATA_W-1:0] rf_write_data;

    // Requester / register-file side.
    modport master (
        output a_valid, a_reg, a_data,
        output b_valid, b_reg, b_data,
        input  a_ready, b_ready,
        input  rf_write_en, rf_write_reg, rf_write_data
    );

    // Arbiter side.
    modport slave (
        input  a_valid, a_reg, a_data,
        input  b_valid, b_reg, b_data,
        output a_ready, b_ready,
        output rf_write_en, rf_write_reg, rf_write_data
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Busy-register scoreboard: decode claims destinations, granted writebacks release them.
module rf_scoreboard
    import regfile_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REG = DEFAULT_NUM_REG
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               claim_en,
    input  reg_idx_t           claim_reg,
    input  logic               clr_en,
    input  reg_idx_t           clr_reg,
    input  reg_idx_t           chk_rs1,
    input  reg_idx_t           chk_rs2,
    input  reg_idx_t           chk_rd,
    output logic               hazard,
    output logic [NUM_REG-1:0] busy_mask,
    output logic               claim_err
);

    logic [NUM_REG-1:0] busy_q, busy_d;
    logic               claim_err_q, claim_err_d;
    logic               claim_live;

    // Next scoreboard: clear first so a same-edge claim of the same register wins.
    always_comb begin
        busy_d      = busy_q;
        claim_err_d = claim_err_q;
        claim_live  = claim_en && !is_x0(claim_reg);
        if (clr_en && !is_x0(clr_reg)) begin
            busy_d[clr_reg] = 1'b0;
        end
        if (claim_live) begin
            busy_d[claim_reg] = 1'b1;
            if (busy_q[claim_reg]) begin
                claim_err_d = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard and sticky error state.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q      <= '0;
            claim_err_q <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            claim_err_q <= claim_err_d;
        end
    end

    // Hazard lookup against the current (registered) scoreboard.
    always_comb begin
        hazard = busy_q[chk_rs1] | busy_q[chk_rs2] | busy_q[chk_rd];
    end

    assign busy_mask = busy_q;
    assign claim_err = claim_err_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between ALU (A) and load/CSR (B) writebacks.
module regfile_wb_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REG  = DEFAULT_NUM_REG,
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  wb,
    input  logic                 claim_en,
    input  reg_idx_t             claim_reg,
    input  reg_idx_t             chk_rs1,
    input  reg_idx_t             chk_rs2,
    input  reg_idx_t             chk_rd,
    output logic                 hazard,
    output logic [NUM_REG-1:0]   busy_mask,
    output logic                 claim_err
);

    localparam int unsigned WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    arb_state_e        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic              a_gnt, b_gnt, xfer;
    reg_idx_t          win_reg;
    logic [DATA_W-1:0] win_data;

    logic              rf_write_en_q, rf_write_en_d;
    reg_idx_t          rf_write_reg_q, rf_write_reg_d;
    logic [DATA_W-1:0] rf_write_data_q, rf_write_data_d;

    // Grant selection, B wait counter and priority FSM next state.
    always_comb begin
        a_gnt      = 1'b0;
        b_gnt      = 1'b0;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;

        if (!reset) begin
            case (state_q)
                PRIO_A: begin
                    a_gnt = wb.a_valid;
                    b_gnt = !wb.a_valid && wb.b_valid;
                end
                PRIO_B: begin
                    b_gnt = wb.b_valid;
                    a_gnt = !wb.b_valid && wb.a_valid;
                end
                default: begin
                    a_gnt = 1'b0;
                    b_gnt = 1'b0;
                end
            endcase
        end

        if (!wb.b_valid || b_gnt) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q < WAIT_W'(MAX_WAIT)) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end

        // Flip to B priority on the same edge the counter reaches its limit,
        // so B wins on the very next cycle.
        case (state_q)
            PRIO_A: begin
                if (wait_cnt_d == WAIT_W'(MAX_WAIT)) begin
                    state_d = PRIO_B;
                end
            end
            PRIO_B: begin
                if (b_gnt || !wb.b_valid) begin
                    state_d = PRIO_A;
                end
            end
            default: state_d = PRIO_A;
        endcase
    end

    // Winner mux and next value of the registered write port.
    always_comb begin
        xfer     = a_gnt || b_gnt;
        win_reg  = b_gnt ? wb.b_reg  : wb.a_reg;
        win_data = b_gnt ? wb.b_data : wb.a_data;

        rf_write_en_d   = xfer && !is_x0(win_reg);
        rf_write_reg_d  = rf_write_reg_q;
        rf_write_data_d = rf_write_data_q;
        if (xfer) begin
            rf_write_reg_d  = win_reg;
            rf_write_data_d = win_data;
        end
    end

    // FSM, wait counter and output stage registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= PRIO_A;
            wait_cnt_q      <= '0;
            rf_write_en_q   <= 1'b0;
            rf_write_reg_q  <= '0;
            rf_write_data_q <= '0;
        end else begin
            state_q         <= state_d;
            wait_cnt_q      <= wait_cnt_d;
            rf_write_en_q   <= rf_write_en_d;
            rf_write_reg_q  <= rf_write_reg_d;
            rf_write_data_q <= rf_write_data_d;
        end
    end

    assign wb.a_ready       = a_gnt;
    assign wb.b_ready       = b_gnt;
    assign wb.rf_write_en   = rf_write_en_q;
    assign wb.rf_write_reg  = rf_write_reg_q;
    assign wb.rf_write_data = rf_write_data_q;

    rf_scoreboard #(
        .NUM_REG (NUM_REG)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .claim_en  (claim_en),
        .claim_reg (claim_reg),
        .clr_en    (rf_write_en_d),
        .clr_reg   (win_reg),
        .chk_rs1   (chk_rs1),
        .chk_rs2   (chk_rs2),
        .chk_rd    (chk_rd),
        .hazard    (hazard),
        .busy_mask (busy_mask),
        .claim_err (claim_err)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;
    import regfile_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic        claim_en;
    reg_idx_t    claim_reg;
    reg_idx_t    chk_rs1, chk_rs2, chk_rd;
    logic        hazard;
    logic [31:0] busy_mask;
    logic        claim_err;

    int total = 0;
    int bad   = 0;

    regfile_wb_arbiter_if #(.DATA_W(32)) wb ();

    regfile_wb_arbiter #(
        .NUM_REG  (32),
        .DATA_W   (32),
        .MAX_WAIT (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wb        (wb),
        .claim_en  (claim_en),
        .claim_reg (claim_reg),
        .chk_rs1   (chk_rs1),
        .chk_rs2   (chk_rs2),
        .chk_rd    (chk_rd),
        .hazard    (hazard),
        .busy_mask (busy_mask),
        .claim_err (claim_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] b_pat;

    initial begin
        reset      = 1'b1;
        claim_en   = 1'b0;
        claim_reg  = '0;
        chk_rs1    = '0;
        chk_rs2    = '0;
        chk_rd     = '0;
        wb.a_valid = 1'b0;
        wb.a_reg   = '0;
        wb.a_data  = '0;
        wb.b_valid = 1'b0;
        wb.b_reg   = '0;
        wb.b_data  = '0;
        tick();
        tick();

        // Reset state, and no grant while reset is high.
        check("rst_en",    64'(wb.rf_write_en), 64'd0);
        check("rst_reg",   64'(wb.rf_write_reg), 64'd0);
        check("rst_data",  64'(wb.rf_write_data), 64'd0);
        check("rst_busy",  64'(busy_mask), 64'd0);
        check("rst_cerr",  64'(claim_err), 64'd0);
        wb.a_valid = 1'b1;
        wb.a_reg   = 5'd4;
        #1;
        check("rst_a_rdy", 64'(wb.a_ready), 64'd0);
        tick();
        check("rst_no_wr", 64'(wb.rf_write_en), 64'd0);
        wb.a_valid = 1'b0;
        reset      = 1'b0;
        tick();

        // Single A write, one-cycle latency, then idle.
        wb.a_valid = 1'b1;
        wb.a_reg   = 5'd5;
        wb.a_data  = 32'hDEAD_BEEF;
        #1;
        check("a1_rdy",  64'(wb.a_ready), 64'd1);
        check("a1_brdy", 64'(wb.b_ready), 64'd0);
        tick();
        wb.a_valid = 1'b0;
        check("a1_en",   64'(wb.rf_write_en), 64'd1);
        check("a1_reg",  64'(wb.rf_write_reg), 64'd5);
        check("a1_data", 64'(wb.rf_write_data), 64'hDEAD_BEEF);
        tick();
        check("a1_idle", 64'(wb.rf_write_en), 64'd0);

        // Both valid: A,A,A,B,A,A,A,B with a write every cycle.
        b_pat      = 8'b1000_1000;
        wb.a_valid = 1'b1;
        wb.a_reg   = 5'd1;
        wb.a_data  = 32'hAAAA_0001;
        wb.b_valid = 1'b1;
        wb.b_reg   = 5'd2;
        wb.b_data  = 32'hBBBB_0002;
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("arb_b_rdy%0d", i), 64'(wb.b_ready), 64'(b_pat[i]));
            check($sformatf("arb_a_rdy%0d", i), 64'(wb.a_ready), 64'(!b_pat[i]));
            tick();
            check($sformatf("arb_en%0d", i),  64'(wb.rf_write_en), 64'd1);
            check($sformatf("arb_reg%0d", i), 64'(wb.rf_write_reg), b_pat[i] ? 64'd2 : 64'd1);
        end
        wb.a_valid = 1'b0;
        wb.b_valid = 1'b0;
        tick();

        // Claim r7 and check hazard lookup on each query port.
        claim_en  = 1'b1;
        claim_reg = 5'd7;
        tick();
        claim_en  = 1'b0;
        check("clm7_busy", 64'(busy_mask), 64'h80);
        chk_rs1 = 5'd7;
        #1;
        check("haz_rs1", 64'(hazard), 64'd1);
        chk_rs1 = 5'd6;
        chk_rd  = 5'd7;
        #1;
        check("haz_rd", 64'(hazard), 64'd1);
        chk_rd  = 5'd0;
        #1;
        check("haz_none", 64'(hazard), 64'd0);
        chk_rs1 = 5'd7;

        // B write to x0: accepted, no write, scoreboard untouched.
        wb.b_valid = 1'b1;
        wb.b_reg   = 5'd0;
        wb.b_data  = 32'h0000_0123;
        #1;
        check("x0_brdy", 64'(wb.b_ready), 64'd1);
        tick();
        wb.b_valid = 1'b0;
        check("x0_en",   64'(wb.rf_write_en), 64'd0);
        check("x0_busy", 64'(busy_mask), 64'h80);

        // A writes r7: hazard drops together with the write output.
        wb.a_valid = 1'b1;
        wb.a_reg   = 5'd7;
        wb.a_data  = 32'h0000_0077;
        #1;
        check("w7_haz_pre", 64'(hazard), 64'd1);
        tick();
        wb.a_valid = 1'b0;
        check("w7_en",   64'(wb.rf_write_en), 64'd1);
        check("w7_haz",  64'(hazard), 64'd0);
        check("w7_busy", 64'(busy_mask), 64'd0);

        // Same-edge claim and write of r7: claim wins.
        claim_en   = 1'b1;
        claim_reg  = 5'd7;
        wb.a_valid = 1'b1;
        wb.a_reg   = 5'd7;
        tick();
        claim_en   = 1'b0;
        wb.a_valid = 1'b0;
        check("same_busy", 64'(busy_mask), 64'h80);
        check("same_cerr", 64'(claim_err), 64'd0);
        wb.a_valid = 1'b1;
        tick();
        wb.a_valid = 1'b0;
        check("rel7_busy", 64'(busy_mask), 64'd0);

        // Claim to x0 is ignored.
        claim_en  = 1'b1;
        claim_reg = 5'd0;
        tick();
        check("clm0_busy", 64'(busy_mask), 64'd0);

        // Double claim of r3 sets the sticky error.
        claim_reg = 5'd3;
        tick();
        check("clm3_cerr0", 64'(claim_err), 64'd0);
        tick();
        claim_en  = 1'b0;
        check("clm3_cerr1", 64'(claim_err), 64'd1);
        check("clm3_busy",  64'(busy_mask), 64'h08);
        wb.a_valid = 1'b1;
        wb.a_reg   = 5'd3;
        tick();
        wb.a_valid = 1'b0;
        tick();
        check("clm3_sticky", 64'(claim_err), 64'd1);
        check("clm3_clr",    64'(busy_mask), 64'd0);

        // Build busy 0xA0, then reset during a burst.
        claim_en  = 1'b1;
        claim_reg = 5'd5;
        tick();
        claim_reg = 5'd7;
        tick();
        claim_en  = 1'b0;
        check("pre_busy", 64'(busy_mask), 64'hA0);
        wb.a_valid = 1'b1;
        wb.a_reg   = 5'd1;
        wb.a_data  = 32'h0000_0011;
        wb.b_valid = 1'b1;
        wb.b_reg   = 5'd2;
        wb.b_data  = 32'h0000_0022;
        tick();
        check("pre_en", 64'(wb.rf_write_en), 64'd1);
        reset = 1'b1;
        #1;
        check("mr_a_rdy", 64'(wb.a_ready), 64'd0);
        check("mr_b_rdy", 64'(wb.b_ready), 64'd0);
        tick();
        check("mr_en",   64'(wb.rf_write_en), 64'd0);
        check("mr_reg",  64'(wb.rf_write_reg), 64'd0);
        check("mr_data", 64'(wb.rf_write_data), 64'd0);
        check("mr_busy", 64'(busy_mask), 64'd0);
        check("mr_cerr", 64'(claim_err), 64'd0);
        tick();
        check("mr_en2",  64'(wb.rf_write_en), 64'd0);
        reset = 1'b0;

        // Fresh PRIO_A with cleared counter: A,A,A,B again.
        b_pat = 8'b0000_1000;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("post_b_rdy%0d", i), 64'(wb.b_ready), 64'(b_pat[i]));
            check($sformatf("post_a_rdy%0d", i), 64'(wb.a_ready), 64'(!b_pat[i]));
            tick();
            check($sformatf("post_reg%0d", i), 64'(wb.rf_write_reg), b_pat[i] ? 64'd2 : 64'd1);
        end
        wb.a_valid = 1'b0;
        wb.b_valid = 1'b0;
        tick();
        check("end_idle", 64'(wb.rf_write_en), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
